if_fetch_queue: RTL

Parametrised instruction-fetch stage with a decoupling prefetch queue between instruction memory and decode. It holds the fetch PC and issues one synchronous instruction-memory read per cycle while queue space allows. It buffers returned instructions with their PCs and hands them to decode over a valid/ready handshake. Redirects from decode (branch/jump target) or from the return-address path flush the queue and any in-flight read, and restart fetch at the new target.

---
 rtl/if_fetch_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues one synchronous imem read per cycle while queue
// space allows, buffers {instr, pc} entries and hands them to decode via valid/ready.
module if_fetch_queue #(
  parameter int unsigned     AW       = 16,
  parameter int unsigned     IW       = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  input  logic          ret_valid,
  input  logic [AW-1:0] ret_pc,
  output logic          imem_rd_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_pc_inc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] pc;
  logic [IW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic          kill;

  logic          redir_any;
  logic [AW-1:0] target;
  logic          pop;
  logic          issue;
  logic          capture;
  logic [CW:0]   pending;

  always_comb begin
    redir_any  = ret_valid | redir_valid;
    target     = ret_valid ? ret_pc : redir_pc;
    out_valid  = (count != '0) & ~redir_any;
    pop        = out_valid & out_ready;
    pending    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue      = redir_any | (pending < {1'b0, DEPTH_C});
    imem_rd_en = issue & rst;
    imem_addr  = redir_any ? target : pc;
    // A response landing in a redirect cycle belongs to the old stream and is dropped.
    capture    = inflight & ~kill & ~redir_any;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      pc          <= imem_addr + AW'(issue);
      inflight    <= issue;
      inflight_pc <= imem_addr;
      if (redir_any) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
        kill   <= 1'b0;
      end else begin
        if (capture) wr_ptr <= wr_ptr + PW'(1);
        if (pop)     rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(capture) - CW'(pop);
      end
    end
  end

  assign out_instr  = q_instr[rd_ptr];
  assign out_pc     = q_pc[rd_ptr];
  assign out_pc_inc = out_pc + AW'(1);

  count_in_range: assert property (@(posedge clk) disable iff (!rst) count <= DEPTH_C);

endmodule
